// File: rtl/vend_pkg.sv
// Shared vending definitions: change codes, coin encodings and dispenser FSM states.
// Also holds the helpers that choose the next coin for an outstanding change amount.
package vend_pkg;

    typedef logic [1:0] chg_t;

    localparam chg_t CHG_NONE = 2'b00;
    localparam chg_t CHG_5    = 2'b01;
    localparam chg_t CHG_10   = 2'b10;
    localparam chg_t CHG_15   = 2'b11;

    localparam logic COIN_NICKEL = 1'b0;
    localparam logic COIN_DIME   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VEND_REQ,
        ST_VEND_REL,
        ST_COIN_REQ,
        ST_COIN_REL,
        ST_DONE,
        ST_FAULT
    } state_t;

    // A dime is only chosen when at least 10c is owed, so remaining never underflows.
    function automatic logic coin_for(input chg_t rem);
        return (rem >= CHG_10) ? COIN_DIME : COIN_NICKEL;
    endfunction

    function automatic chg_t coin_value(input logic ct);
        return (ct == COIN_DIME) ? CHG_10 : CHG_5;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Strobe input and actuator handshakes of the change dispenser.
// The master side is the vending FSM plus the mechanics; the slave side is the dispenser.
interface change_dispenser_if;
    import vend_pkg::*;

    logic dispense;
    chg_t change;
    logic vend_req;
    logic vend_done;
    logic coin_req;
    logic coin_type;
    logic coin_ack;
    logic busy;
    logic done;
    logic overflow;
    logic fault;

    modport master (
        output dispense, change, vend_done, coin_ack,
        input  vend_req, coin_req, coin_type, busy, done, overflow, fault
    );

    modport slave (
        input  dispense, change, vend_done, coin_ack,
        output vend_req, coin_req, coin_type, busy, done, overflow, fault
    );

endinterface

// File: rtl/hs_timeout.sv
// Handshake watchdog: counts while enabled and flags once the count reaches ACK_TIMEOUT.
module hs_timeout #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    assign expired = (cnt == CNT_W'(ACK_TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/change_dispenser.sv
// Vend-then-change back end: motor handshake, then nickel/dime ejection, with a one-deep
// pending slot for strobes that arrive while busy and a sticky timeout fault.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input logic               clk,
    input logic               rst,
    change_dispenser_if.slave bus
);

    state_t state, state_nx;
    chg_t   remaining, remaining_nx;
    chg_t   pend_chg, pend_chg_nx;
    logic   pend_vld, pend_vld_nx;
    logic   overflow_q, overflow_nx;

    logic   vend_req_q, coin_req_q, coin_type_q, busy_q, done_q, fault_q;
    logic   tmo_clear, tmo_en, expired;

    hs_timeout #(
        .CNT_W       (CNT_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .expired (expired)
    );

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        pend_chg_nx  = pend_chg;
        pend_vld_nx  = pend_vld;
        overflow_nx  = overflow_q;

        case (state)
            ST_IDLE: begin
                if (bus.dispense) begin
                    remaining_nx = bus.change;
                    state_nx     = ST_VEND_REQ;
                end
            end
            ST_VEND_REQ: begin
                if (bus.vend_done)
                    state_nx = ST_VEND_REL;
                else if (expired)
                    state_nx = ST_FAULT;
            end
            ST_VEND_REL: begin
                if (!bus.vend_done)
                    state_nx = (remaining == CHG_NONE) ? ST_DONE : ST_COIN_REQ;
                else if (expired)
                    state_nx = ST_FAULT;
            end
            ST_COIN_REQ: begin
                if (bus.coin_ack) begin
                    remaining_nx = remaining - coin_value(coin_for(remaining));
                    state_nx     = ST_COIN_REL;
                end else if (expired) begin
                    state_nx = ST_FAULT;
                end
            end
            ST_COIN_REL: begin
                if (!bus.coin_ack)
                    state_nx = (remaining == CHG_NONE) ? ST_DONE : ST_COIN_REQ;
                else if (expired)
                    state_nx = ST_FAULT;
            end
            ST_DONE: begin
                // A strobe landing on DONE with the slot empty is consumed directly.
                if (pend_vld) begin
                    remaining_nx = pend_chg;
                    pend_vld_nx  = 1'b0;
                    state_nx     = ST_VEND_REQ;
                end else if (bus.dispense) begin
                    remaining_nx = bus.change;
                    state_nx     = ST_VEND_REQ;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_FAULT;
        endcase

        if (bus.dispense && state != ST_IDLE && state != ST_FAULT) begin
            if (pend_vld) begin
                overflow_nx = 1'b1;
            end else if (state != ST_DONE) begin
                pend_vld_nx = 1'b1;
                pend_chg_nx = bus.change;
            end
        end
    end

    assign tmo_clear = (state_nx != state);
    assign tmo_en    = (state == ST_VEND_REQ) || (state == ST_VEND_REL) ||
                       (state == ST_COIN_REQ) || (state == ST_COIN_REL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            remaining   <= CHG_NONE;
            pend_chg    <= CHG_NONE;
            pend_vld    <= 1'b0;
            overflow_q  <= 1'b0;
            vend_req_q  <= 1'b0;
            coin_req_q  <= 1'b0;
            coin_type_q <= COIN_NICKEL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state       <= state_nx;
            remaining   <= remaining_nx;
            pend_chg    <= pend_chg_nx;
            pend_vld    <= pend_vld_nx;
            overflow_q  <= overflow_nx;
            vend_req_q  <= (state_nx == ST_VEND_REQ);
            coin_req_q  <= (state_nx == ST_COIN_REQ);
            coin_type_q <= (state_nx == ST_COIN_REQ) ? coin_for(remaining_nx) : COIN_NICKEL;
            busy_q      <= (state_nx != ST_IDLE) && (state_nx != ST_FAULT);
            done_q      <= (state_nx == ST_DONE);
            fault_q     <= (state_nx == ST_FAULT);
        end
    end

    assign bus.vend_req  = vend_req_q;
    assign bus.coin_req  = coin_req_q;
    assign bus.coin_type = coin_type_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overflow  = overflow_q;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: the bench plays vending FSM, motor and coin mechanism.
module tb_change_dispenser;

    localparam int unsigned TMO = 255;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   ack_cycles = 0;
    int   ack_base;

    change_dispenser_if bus ();

    change_dispenser #(
        .ACK_TIMEOUT (TMO),
        .CNT_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.coin_ack) ack_cycles++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return bus.vend_req;
            1:       return bus.coin_req;
            default: return bus.done;
        endcase
    endfunction

    task automatic wait_sig(input int which, input logic lvl, input string tag);
        int n = 0;
        while (sel(which) !== lvl && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, sel(which), lvl);
    endtask

    task automatic strobe(input logic [1:0] c);
        bus.dispense = 1'b1;
        bus.change   = c;
        @(negedge clk);
        bus.dispense = 1'b0;
        bus.change   = 2'b00;
    endtask

    task automatic run_vend(input int delay, input string tag);
        wait_sig(0, 1'b1, {tag, "_vreq"});
        repeat (delay) @(negedge clk);
        bus.vend_done = 1'b1;
        wait_sig(0, 1'b0, {tag, "_vrel"});
        bus.vend_done = 1'b0;
    endtask

    task automatic run_coin(input logic exp_type, input string tag);
        wait_sig(1, 1'b1, {tag, "_creq"});
        check({tag, "_ctype"}, bus.coin_type, exp_type);
        bus.coin_ack = 1'b1;
        wait_sig(1, 1'b0, {tag, "_crel"});
        bus.coin_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.dispense = 1'b0;
        bus.change = 2'b00;
        bus.vend_done = 1'b0;
        bus.coin_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_vend_req", bus.vend_req, 0);
        check("rst_coin_req", bus.coin_req, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_fault", bus.fault, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: no change
        ack_base = ack_cycles;
        strobe(2'b00);
        check("t1_vreq_latency", bus.vend_req, 1);
        check("t1_busy", bus.busy, 1);
        run_vend(3, "t1");
        wait_sig(2, 1'b1, "t1_done");
        @(negedge clk);
        check("t1_done_width", bus.done, 0);
        check("t1_idle", bus.busy, 0);
        check("t1_no_coin", ack_cycles - ack_base, 0);

        // 2: 15c -> dime, nickel
        ack_base = ack_cycles;
        strobe(2'b11);
        run_vend(1, "t2");
        run_coin(1'b1, "t2a");
        run_coin(1'b0, "t2b");
        wait_sig(2, 1'b1, "t2_done");
        @(negedge clk);
        check("t2_idle", bus.busy, 0);
        check("t2_acks", ack_cycles - ack_base, 2);

        // 3: second strobe mid-vend chains without an IDLE gap
        ack_base = ack_cycles;
        strobe(2'b10);
        strobe(2'b01);
        run_vend(2, "t3a");
        run_coin(1'b1, "t3a");
        wait_sig(2, 1'b1, "t3_done1");
        @(negedge clk);
        check("t3_chain_vreq", bus.vend_req, 1);
        check("t3_chain_done", bus.done, 0);
        check("t3_chain_busy", bus.busy, 1);
        run_vend(1, "t3b");
        run_coin(1'b0, "t3b");
        wait_sig(2, 1'b1, "t3_done2");
        @(negedge clk);
        check("t3_idle", bus.busy, 0);
        check("t3_overflow", bus.overflow, 0);
        check("t3_acks", ack_cycles - ack_base, 2);

        // 4: three back-to-back strobes, third dropped
        ack_base = ack_cycles;
        bus.dispense = 1'b1;
        bus.change = 2'b01;
        @(negedge clk);
        bus.change = 2'b10;
        @(negedge clk);
        check("t4_overflow_early", bus.overflow, 0);
        bus.change = 2'b11;
        @(negedge clk);
        bus.dispense = 1'b0;
        bus.change = 2'b00;
        check("t4_overflow", bus.overflow, 1);
        run_vend(1, "t4a");
        run_coin(1'b0, "t4a");
        wait_sig(2, 1'b1, "t4_done1");
        @(negedge clk);
        check("t4_chain_vreq", bus.vend_req, 1);
        run_vend(1, "t4b");
        run_coin(1'b1, "t4b");
        wait_sig(2, 1'b1, "t4_done2");
        @(negedge clk);
        check("t4_idle", bus.busy, 0);
        check("t4_idle_vreq", bus.vend_req, 0);
        check("t4_acks", ack_cycles - ack_base, 2);

        // 5: coin ack never arrives
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        strobe(2'b01);
        run_vend(1, "t5");
        wait_sig(1, 1'b1, "t5_creq");
        repeat (TMO) @(negedge clk);
        check("t5_pre_fault", bus.fault, 0);
        check("t5_pre_creq", bus.coin_req, 1);
        @(negedge clk);
        check("t5_fault", bus.fault, 1);
        check("t5_creq_drop", bus.coin_req, 0);
        check("t5_busy", bus.busy, 0);
        strobe(2'b10);
        @(negedge clk);
        check("t5_ignored_vreq", bus.vend_req, 0);
        check("t5_ignored_busy", bus.busy, 0);
        check("t5_no_overflow", bus.overflow, 0);
        check("t5_sticky", bus.fault, 1);

        // 6: reset mid coin handshake
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        strobe(2'b11);
        run_vend(1, "t6a");
        wait_sig(1, 1'b1, "t6_creq");
        #2 rst = 1'b1;
        #1 check("t6_async_drop", bus.coin_req, 0);
        @(negedge clk);
        rst = 1'b0;
        check("t6_fault_clr", bus.fault, 0);
        check("t6_busy_clr", bus.busy, 0);
        @(negedge clk);
        ack_base = ack_cycles;
        strobe(2'b01);
        check("t6_vreq", bus.vend_req, 1);
        run_vend(2, "t6b");
        run_coin(1'b0, "t6b");
        wait_sig(2, 1'b1, "t6_done");
        @(negedge clk);
        check("t6_idle", bus.busy, 0);
        check("t6_acks", ack_cycles - ack_base, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
